uart_upgrade_loader: RTL
========================

UART_UPGRADE_LOADER -- requirements
Module: uart_upgrade_loader

Interface
REQ-001 Parameter RAM_SIZE, default 16'h4000, image size in bytes; SHALL be a multiple of 4.
REQ-002 Parameter XLEN, default 32, RAM write data width; only 32 is supported.
REQ-003 Parameter TIMEOUT_CYC, default 20'd1000000, maximum number of idle clk cycles allowed between received bytes once loading has started.
REQ-004 clk  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 sw_uart_upgrade_b  input  1  low = load image over UART, high = boot the existing RAM contents.
REQ-007 rx_valid  input  1  one-cycle strobe from the UART receiver: rx_data is valid.
REQ-008 rx_data  input  8  received byte.
REQ-009 ram_we  output  1  one-cycle RAM word write strobe.
REQ-010 ram_addr  output  $clog2(RAM_SIZE/4)  RAM word address.
REQ-011 ram_wdata  output  XLEN  RAM word write data.
REQ-012 cpu_hold  output  1  high = hold the CPU in reset.
REQ-013 done  output  1  image loaded or bypassed; the CPU is released.
REQ-014 err  output  1  inter-byte timeout occurred; sticky.
REQ-015 byte_cnt  output  16  number of bytes accepted so far.

Function
REQ-016 States SHALL be IDLE, LOAD, WRITE, DONE and ERROR, encoded in a single registered state variable.
REQ-017 IDLE, sw_uart_upgrade_b=1: next state SHALL be DONE.
REQ-018 IDLE, sw_uart_upgrade_b=0: next state SHALL be LOAD.
REQ-019 sw_uart_upgrade_b SHALL be sampled only in IDLE; changes in any other state SHALL be ignored.
REQ-020 LOAD, rx_valid=1: the byte SHALL be stored into word-buffer lane byte_cnt[1:0], little-endian (lane 0 = bits [7:0]), and byte_cnt SHALL increment by 1.
REQ-021 When the accepted byte is lane 3, next state SHALL be WRITE.
REQ-022 WRITE: ram_we=1 for exactly one cycle, with ram_addr=(byte_cnt-1)>>2 and ram_wdata equal to the 4 assembled bytes.
REQ-023 Write latency SHALL be 1 clk after the rx_valid of lane 3.
REQ-024 WRITE exit: next state SHALL be DONE if byte_cnt==RAM_SIZE, otherwise LOAD.
REQ-025 rx_valid asserted while in WRITE SHALL be accepted exactly as in LOAD; no byte SHALL be lost.
REQ-026 The write for a byte accepted in WRITE SHALL occur no earlier than the cycle after the current write.
REQ-027 ram_we SHALL never be asserted outside WRITE.
REQ-028 At most one write SHALL occur per word address, and addresses SHALL be strictly increasing from 0.
REQ-029 Timeout counter: SHALL clear on every accepted byte, count in LOAD and WRITE only while byte_cnt>0, and saturate.
REQ-030 Timeout: when the counter reaches TIMEOUT_CYC, next state SHALL be ERROR.
REQ-031 A partial word SHALL NOT be written on timeout.
REQ-032 Before the first byte the loader SHALL wait indefinitely.
REQ-033 DONE SHALL be terminal until rst.
REQ-034 In DONE: cpu_hold=0 and done=1.
REQ-035 ERROR SHALL be terminal until rst.
REQ-036 In ERROR: err=1, cpu_hold=1 and done=0.
REQ-037 rx_valid in IDLE, DONE or ERROR SHALL be ignored, with byte_cnt unchanged.
REQ-038 cpu_hold SHALL be 1 in IDLE, LOAD, WRITE and ERROR.
REQ-039 byte_cnt SHALL never exceed RAM_SIZE.
REQ-040 byte_cnt SHALL NOT wrap.

Reset
REQ-041 rst=1 at a clock edge SHALL force state=IDLE, byte_cnt=0, word buffer=0 and timeout counter=0.
REQ-042 Output values while rst=1 and on the cycle after: ram_we=0, ram_addr=0, ram_wdata=0, cpu_hold=1, done=0, err=0.
REQ-043 rst asserted mid-LOAD or mid-WRITE SHALL abort the load with no further write; a new load SHALL restart at address 0.

Verification
REQ-044 Bypass: sw_uart_upgrade_b=1, release rst -> done=1 and cpu_hold=0 two cycles later; no ram_we ever.
REQ-045 Full load, RAM_SIZE=16: bytes 00..0F with gaps of 5 cycles -> 4 writes, to addr 0..3, with data 03020100, 07060504, 0B0A0908, 0F0E0D0C; then done=1 and cpu_hold=0.
REQ-046 Back-to-back bytes: rx_valid high every cycle for 8 bytes, including during WRITE -> writes 03020100 @0 and 07060504 @1, byte_cnt=8, no byte lost.
REQ-047 Timeout, TIMEOUT_CYC=50: send 6 bytes, then silence -> one write @0, err=1 exactly 50 cycles after the last byte, cpu_hold=1, no write @1.
REQ-048 Reset mid-load: after 5 bytes assert rst, then resend the full image -> writes restart at addr 0 with correct data and byte_cnt ends at RAM_SIZE.
REQ-049 Ignored input: rx_valid pulses after done=1, and sw_uart_upgrade_b toggled during LOAD -> no ram_we, byte_cnt and state unchanged.

Source files
------------

// File: rtl/uart_upgrade_loader.sv
// Boot-time image loader: assembles UART bytes into little-endian 32-bit words,
// writes them to RAM from address 0 and holds the CPU in reset until finished.
module uart_upgrade_loader #(
    parameter logic [15:0] RAM_SIZE    = 16'h4000,
    parameter int          XLEN        = 32,
    parameter logic [19:0] TIMEOUT_CYC = 20'd1000000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sw_uart_upgrade_b,
    input  logic                            rx_valid,
    input  logic [7:0]                      rx_data,
    output logic                            ram_we,
    output logic [$clog2(RAM_SIZE/4)-1:0]   ram_addr,
    output logic [XLEN-1:0]                 ram_wdata,
    output logic                            cpu_hold,
    output logic                            done,
    output logic                            err,
    output logic [15:0]                     byte_cnt
);

    localparam int AW = $clog2(RAM_SIZE/4);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE,
        ERROR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] word_buf;
    logic [19:0]     to_cnt;
    logic            full;
    logic            accept;
    logic            counting;
    logic            to_hit;

    // A byte arriving during WRITE is taken as lane 0 of the next word, unless the image is complete.
    assign full     = (byte_cnt == RAM_SIZE);
    assign accept   = rx_valid && ((state == LOAD) || ((state == WRITE) && !full));
    assign counting = ((state == LOAD) || (state == WRITE)) && (byte_cnt != 16'd0);
    // Fire on the edge where the counter would reach TIMEOUT_CYC, so err rises exactly TIMEOUT_CYC cycles after the last byte.
    assign to_hit   = counting && !accept && (({1'b0, to_cnt} + 21'd1) >= {1'b0, TIMEOUT_CYC});

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        cpu_hold  = 1'b1;
        done      = 1'b0;
        err       = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = sw_uart_upgrade_b ? DONE : LOAD;
            end
            LOAD: begin
                if (to_hit) begin
                    state_nxt = ERROR;
                end else if (accept && (byte_cnt[1:0] == 2'd3)) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                if (to_hit) begin
                    state_nxt = ERROR;
                end else if (full) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = LOAD;
                end
            end
            DONE:    state_nxt = DONE;
            ERROR:   state_nxt = ERROR;
            default: state_nxt = IDLE;
        endcase

        // Outputs are forced to their reset values for as long as rst is held.
        if (!rst) begin
            case (state)
                WRITE: begin
                    ram_we    = 1'b1;
                    ram_addr  = AW'((byte_cnt - 16'd1) >> 2);
                    ram_wdata = word_buf;
                end
                DONE: begin
                    cpu_hold = 1'b0;
                    done     = 1'b1;
                end
                ERROR: begin
                    err = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt <= 16'd0;
            word_buf <= '0;
            to_cnt   <= 20'd0;
        end else if (accept) begin
            word_buf[{byte_cnt[1:0], 3'b000} +: 8] <= rx_data;
            byte_cnt <= byte_cnt + 16'd1;
            to_cnt   <= 20'd0;
        end else if (counting && (to_cnt != TIMEOUT_CYC)) begin
            to_cnt <= to_cnt + 20'd1;
        end
    end

endmodule
